// File: rtl/rx_pkg.sv
// Shared types and sizing helpers for the receive bit controller.
package rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } rx_state_t;

    function automatic int timer_width(input int clks);
        return (clks <= 2) ? 1 : $clog2(clks);
    endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-period timer: wraps 0..CLKS_PER_BIT-1, flags the bit centre and the cycle before it.
module rx_bit_timer
    import rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic sample,
    output logic pre_sample
);

    localparam int TW = timer_width(CLKS_PER_BIT);
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2);
    localparam logic [TW-1:0] PRE  = TW'(CLKS_PER_BIT / 2 - 1);

    logic [TW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign sample     = (count == HALF);
    assign pre_sample = (count == PRE);

endmodule

// File: rtl/rx_bit_ctrl.sv
// Receive bit controller: synchroniser, start detect, bit timing and stop/parity checking.
// Optional even-parity checking is enabled by defining RX_PARITY_EN.
module rx_bit_ctrl
    import rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10,
    parameter int NUM_BITS     = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic serial_in,
    output logic serial_sync,
    output logic shift_strobe,
    output logic rx_busy,
    output logic packet_done,
    output logic framing_error
`ifdef RX_PARITY_EN
    ,
    output logic parity_error
`endif
);

    localparam int CW = $clog2(NUM_BITS + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(NUM_BITS - 1);

    rx_state_t     state;
    logic [CW-1:0] bit_count;
    logic          sync_meta;
    logic          sync_prev;
    logic [1:0]    sync_fill;
    logic          armed;
    logic          start_edge;
    logic          idle_like;
    logic          sample;
    logic          pre_sample;
    logic          timer_clear;
`ifdef RX_PARITY_EN
    logic          parity_acc;
`endif

    // The reset-value 1s in the sync chain are not real line samples; sync_fill
    // marks when serial_sync carries a genuine sample, so only a real high arms detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta   <= 1'b1;
            serial_sync <= 1'b1;
            sync_prev   <= 1'b1;
            sync_fill   <= 2'b00;
            armed       <= 1'b0;
        end else begin
            sync_meta   <= serial_in;
            serial_sync <= sync_meta;
            sync_prev   <= serial_sync;
            sync_fill   <= {sync_fill[0], 1'b1};
            if (sync_fill[1] && serial_sync) begin
                armed <= 1'b1;
            end
        end
    end

    assign start_edge = armed & sync_prev & ~serial_sync;
    assign idle_like  = (state == IDLE) || (state == DONE);
    assign rx_busy    = (state != IDLE);

    // Timer reads 0 in the start-edge cycle: it is held at 0 whenever the next state is IDLE or DONE.
    assign timer_clear = (idle_like && !start_edge) ||
                         (sample && ((state == START && serial_sync) || state == STOP));

    rx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (timer_clear),
        .sample    (sample),
        .pre_sample(pre_sample)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bit_count     <= '0;
            shift_strobe  <= 1'b0;
            packet_done   <= 1'b0;
            framing_error <= 1'b0;
`ifdef RX_PARITY_EN
            parity_acc    <= 1'b0;
            parity_error  <= 1'b0;
`endif
        end else begin
            // Strobe is registered one cycle early so it is high in the bit-centre cycle itself.
            shift_strobe <= (state == DATA) && pre_sample;
            packet_done  <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    bit_count <= '0;
                    if (start_edge) begin
                        state         <= START;
                        framing_error <= 1'b0;
`ifdef RX_PARITY_EN
                        parity_acc    <= 1'b0;
                        parity_error  <= 1'b0;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                START: begin
                    if (sample) begin
                        state <= serial_sync ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (sample) begin
                        bit_count <= bit_count + 1'b1;
`ifdef RX_PARITY_EN
                        parity_acc <= parity_acc ^ serial_sync;
                        if (bit_count == LAST_BIT) begin
                            state <= PARITY;
                        end
`else
                        if (bit_count == LAST_BIT) begin
                            state <= STOP;
                        end
`endif
                    end
                end
`ifdef RX_PARITY_EN
                PARITY: begin
                    if (sample) begin
                        parity_error <= parity_acc ^ serial_sync;
                        state        <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (sample) begin
                        framing_error <= ~serial_sync;
                        packet_done   <= 1'b1;
                        state         <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_bit_ctrl.sv
// Directed bench for rx_bit_ctrl: table of frames plus reset, glitch, back-to-back and abort sequences.
module tb_rx_bit_ctrl;

    localparam int CLKS = 10;
    localparam int NB   = 8;
`ifdef RX_PARITY_EN
    localparam int FRAME_BITS = NB + 3;
`else
    localparam int FRAME_BITS = NB + 2;
`endif
    // Cycles from the serial_in fall to the first strobe / to packet_done (2 sync cycles included).
    localparam int FIRST_LAT = 2 + CLKS + CLKS / 2;
    localparam int DONE_LAT  = 2 + (FRAME_BITS - 1) * CLKS + CLKS / 2 + 1;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       par_bit;
        logic       exp_fe;
        logic       exp_pe;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic serial_in = 1'b1;
    logic serial_sync, shift_strobe, rx_busy, packet_done, framing_error;
`ifdef RX_PARITY_EN
    logic parity_error;
`endif

    rx_bit_ctrl #(
        .CLKS_PER_BIT(CLKS),
        .NUM_BITS    (NB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .serial_in    (serial_in),
        .serial_sync  (serial_sync),
        .shift_strobe (shift_strobe),
        .rx_busy      (rx_busy),
        .packet_done  (packet_done),
        .framing_error(framing_error)
`ifdef RX_PARITY_EN
        ,
        .parity_error (parity_error)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int   strobe_cyc[$];
    logic strobe_bit[$];
    int   done_cyc[$];
    logic done_fe[$];
    logic done_pe[$];
    int   busy_total = 0;

    always @(negedge clk) begin
        if (shift_strobe) begin
            strobe_cyc.push_back(cyc);
            strobe_bit.push_back(serial_sync);
        end
        if (packet_done) begin
            done_cyc.push_back(cyc);
            done_fe.push_back(framing_error);
`ifdef RX_PARITY_EN
            done_pe.push_back(parity_error);
`else
            done_pe.push_back(1'b0);
`endif
        end
        if (rx_busy) busy_total++;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        serial_in = b;
        repeat (CLKS) @(posedge clk);
        #1;
    endtask

    // Call at posedge+1; returns the cycle in which serial_in fell for the start bit.
    task automatic send_frame(input vec_t v, output int fall);
        fall = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < NB; i++) drive_bit(v.data[i]);
`ifdef RX_PARITY_EN
        drive_bit(v.par_bit);
`endif
        drive_bit(v.stop_bit);
    endtask

    task automatic check_frame(input string tag, input vec_t v, input int fall,
                               input int s0, input int d0);
        logic [7:0] got;
        int bad;
        check({tag, " strobes present"}, int'(strobe_cyc.size() >= s0 + NB), 1);
        check({tag, " done present"}, int'(done_cyc.size() > d0), 1);
        if (strobe_cyc.size() < s0 + NB || done_cyc.size() <= d0) return;
        bad = 0;
        for (int i = 0; i < NB; i++) got[i] = strobe_bit[s0 + i];
        for (int i = 1; i < NB; i++)
            if (strobe_cyc[s0 + i] - strobe_cyc[s0 + i - 1] != CLKS) bad++;
        check({tag, " data"}, int'(got), int'(v.data));
        check({tag, " first strobe latency"}, strobe_cyc[s0] - fall, FIRST_LAT);
        check({tag, " strobe spacing errors"}, bad, 0);
        check({tag, " done latency"}, done_cyc[d0] - fall, DONE_LAT);
        check({tag, " framing_error at done"}, int'(done_fe[d0]), int'(v.exp_fe));
`ifdef RX_PARITY_EN
        check({tag, " parity_error at done"}, int'(done_pe[d0]), int'(v.exp_pe));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[3];
        vec_t v;
        vec_t v2;
        int fall, fall2, s0, d0, b0;
        logic [7:0] part;

        vecs[0] = '{data: 8'hA5, stop_bit: 1'b1, par_bit: 1'b0, exp_fe: 1'b0, exp_pe: 1'b0};
        vecs[1] = '{data: 8'h5A, stop_bit: 1'b1, par_bit: 1'b0, exp_fe: 1'b0, exp_pe: 1'b0};
        vecs[2] = '{data: 8'hA5, stop_bit: 1'b0, par_bit: 1'b0, exp_fe: 1'b1, exp_pe: 1'b0};

        rst = 1'b1;
        serial_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset serial_sync", int'(serial_sync), 1);
        check("reset shift_strobe", int'(shift_strobe), 0);
        check("reset rx_busy", int'(rx_busy), 0);
        check("reset packet_done", int'(packet_done), 0);
        check("reset framing_error", int'(framing_error), 0);
`ifdef RX_PARITY_EN
        check("reset parity_error", int'(parity_error), 0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // Table-driven single frames.
        for (int k = 0; k < 3; k++) begin
            s0 = strobe_cyc.size();
            d0 = done_cyc.size();
            send_frame(vecs[k], fall);
            serial_in = 1'b1;
            repeat (5) @(posedge clk);
            #1;
            check_frame($sformatf("vec%0d", k), vecs[k], fall, s0, d0);
            check($sformatf("vec%0d strobe count", k), strobe_cyc.size() - s0, NB);
            check($sformatf("vec%0d done count", k), done_cyc.size() - d0, 1);
            check($sformatf("vec%0d rx_busy idle", k), int'(rx_busy), 0);
            check($sformatf("vec%0d framing_error sticky", k), int'(framing_error), int'(vecs[k].exp_fe));
            repeat (10) @(posedge clk);
            #1;
        end

        // framing_error holds until the next start edge.
        repeat (30) @(posedge clk);
        #1;
        check("framing_error still set", int'(framing_error), 1);

        // Three-cycle glitch: false start, no strobes, no done; start detect clears framing_error.
        s0 = strobe_cyc.size();
        d0 = done_cyc.size();
        b0 = busy_total;
        serial_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 serial_in = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("glitch strobes", strobe_cyc.size() - s0, 0);
        check("glitch done", done_cyc.size() - d0, 0);
        check("glitch busy in 4..6", int'((busy_total - b0) >= 4 && (busy_total - b0) <= 6), 1);
        check("glitch cleared framing_error", int'(framing_error), 0);

        // Line held low through and after reset.
        serial_in = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        s0 = strobe_cyc.size();
        d0 = done_cyc.size();
        b0 = busy_total;
        repeat (50) @(posedge clk);
        #1;
        check("low line busy", busy_total - b0, 0);
        check("low line strobes", strobe_cyc.size() - s0, 0);
        serial_in = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("low line no done", done_cyc.size() - d0, 0);
        v = '{data: 8'h3C, stop_bit: 1'b1, par_bit: 1'b0, exp_fe: 1'b0, exp_pe: 1'b0};
        s0 = strobe_cyc.size();
        d0 = done_cyc.size();
        send_frame(v, fall);
        repeat (5) @(posedge clk);
        #1;
        check_frame("after low line", v, fall, s0, d0);
        repeat (10) @(posedge clk);
        #1;

        // Back-to-back frames.
        v  = '{data: 8'hFF, stop_bit: 1'b1, par_bit: 1'b0, exp_fe: 1'b0, exp_pe: 1'b0};
        v2 = '{data: 8'h00, stop_bit: 1'b1, par_bit: 1'b0, exp_fe: 1'b0, exp_pe: 1'b0};
        s0 = strobe_cyc.size();
        d0 = done_cyc.size();
        send_frame(v, fall);
        send_frame(v2, fall2);
        repeat (5) @(posedge clk);
        #1;
        check_frame("b2b first", v, fall, s0, d0);
        check_frame("b2b second", v2, fall2, s0 + NB, d0 + 1);
        check("b2b strobe count", strobe_cyc.size() - s0, 2 * NB);
        check("b2b done count", done_cyc.size() - d0, 2);
        repeat (10) @(posedge clk);
        #1;

        // Abort with rst after the 4th strobe, then a fresh frame.
        part = 8'h81;
        s0 = strobe_cyc.size();
        d0 = done_cyc.size();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(part[i]);
        check("abort strobes before rst", strobe_cyc.size() - s0, 4);
        rst = 1'b1;
        serial_in = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort rx_busy after rst", int'(rx_busy), 0);
        repeat (40) @(posedge clk);
        #1;
        check("abort no further strobes", strobe_cyc.size() - s0, 4);
        check("abort no done", done_cyc.size() - d0, 0);
        v = '{data: 8'h81, stop_bit: 1'b1, par_bit: 1'b1, exp_fe: 1'b0, exp_pe: 1'b1};
        s0 = strobe_cyc.size();
        d0 = done_cyc.size();
        send_frame(v, fall);
        repeat (5) @(posedge clk);
        #1;
        check_frame("after abort", v, fall, s0, d0);
        check("after abort strobe count", strobe_cyc.size() - s0, NB);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
